fact_mul_unit: RTL

Multiplier responder that serves the per-iteration multiply requests issued by the factorial controller. It accepts one iteration value and one running product per request and computes their exact 25-bit product by sequential shift-add over a fixed 9 cycles. It returns the low 16 bits on `ALU_mul` with a one-cycle `done` pulse and an overflow flag. It sits between the factorial control path and the `FACT_reg` accumulator, replacing the combinational ALU multiply path for factorial operations.

---
 rtl/fact_mul_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fact_mul_unit.sv
// fact_mul_unit
// Multiplier for the factorial datapath. It takes a 9-bit iteration value
// and a 16-bit running product and forms their exact 25-bit product. The
// product is built by shift-add over a fixed 9 cycles. The low 16 bits are
// returned on ALU_mul with a one-cycle done pulse. ovf flags any product
// that does not fit in 16 bits.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   req      : multiply request, sampled only while busy is low
//   op_a     : 9-bit multiplier (iteration value), captured on accept
//   op_b     : 16-bit multiplicand (running product), captured on accept
//   busy     : operation in progress; requests are ignored
//   done     : one-cycle pulse; ALU_mul/ovf are valid from this cycle
//   ALU_mul  : low 16 bits of op_a*op_b, held until the next done
//   ovf      : exact product exceeds 16 bits, updated with ALU_mul
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for req
// MUL   | one shift-add step per cycle, 9 steps (step 0..8)
// DONE  | result valid, done pulse; req here starts the next op directly

module fact_mul_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [8:0]  op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] ALU_mul,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [8:0]  a_reg;
  logic [24:0] b_reg;
  logic [24:0] acc;
  logic [3:0]  step;
  logic [24:0] final_acc;

  // The accumulator value after this cycle's conditional add. On the last
  // step this is the complete product. 511*65535 fits in 25 bits, so this
  // add cannot overflow.
  assign final_acc = acc + (a_reg[0] ? b_reg : 25'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      step    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ALU_mul <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (req) begin
            a_reg <= op_a;
            b_reg <= {9'd0, op_b};
            acc   <= '0;
            step  <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end
        end

        MUL: begin
          acc   <= final_acc;
          a_reg <= a_reg >> 1;
          b_reg <= b_reg << 1;
          step  <= step + 4'd1;
          if (step == 4'd8) begin
            ALU_mul <= final_acc[15:0];
            ovf     <= |final_acc[24:16];
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (req) begin
            // Back-to-back accept. ALU_mul keeps the previous result until
            // this new operation completes.
            a_reg <= op_a;
            b_reg <= {9'd0, op_b};
            acc   <= '0;
            step  <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
